radix4_booth_seq_mult: RTL and testbench

- Iterative signed multiplier that consumes radix-4 Booth digits: recodes multiplier B one overlapping triplet per cycle, forms the selected partial product of A (0, ±A, ±2A), and accumulates into a 2*WIDTH product.
- Consumer end of the Booth encoder path. Used in the Posit FMAU where a low-area mantissa multiply is acceptable.
- Valid/ready handshake on both input and output.

---
 rtl/radix4_booth_seq_mult.sv | 113 +++++++++++
 tb/tb_radix4_booth_seq_mult.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/radix4_booth_seq_mult.sv
// Sequential radix-4 Booth multiplier: one Booth digit per cycle, valid/ready in and out.
// Define BOOTH_EARLY_TERM_EN to finish as soon as the remaining digits are all zero.
module radix4_booth_seq_mult #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product,
  output logic               busy
);

  localparam int N_DIG = WIDTH / 2;
  localparam int CW    = (N_DIG > 1) ? $clog2(N_DIG) : 1;
  localparam int AW    = WIDTH + 2;
  localparam int PW    = 2 * WIDTH;
  localparam logic [CW-1:0] LAST = CW'(N_DIG - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state, state_n;

  logic signed [AW-1:0] a_q, a_n;
  logic [WIDTH:0]       q_q, q_n;
  logic [PW-1:0]        acc_q, acc_n;
  logic [CW-1:0]        cnt_q, cnt_n;

  logic signed [AW-1:0] pp;
  logic [PW-1:0]        ppx;
  logic [WIDTH:0]       q_sh;

  always_comb begin
    pp = '0;
    case (q_q[2:0])
      3'b001, 3'b010: pp = a_q;
      3'b011:         pp = a_q <<< 1;
      3'b100:         pp = -(a_q <<< 1);
      3'b101, 3'b110: pp = -a_q;
      default:        pp = '0;
    endcase
  end

  // Guard bits above 2*WIDTH never reach the product, so the sum is kept modulo 2^(2*WIDTH)
  assign ppx  = {{(PW-AW){pp[AW-1]}}, pp} << {cnt_q, 1'b0};
  assign q_sh = {q_q[WIDTH], q_q[WIDTH], q_q[WIDTH:2]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      a_q   <= '0;
      q_q   <= '0;
      acc_q <= '0;
      cnt_q <= '0;
    end else begin
      state <= state_n;
      a_q   <= a_n;
      q_q   <= q_n;
      acc_q <= acc_n;
      cnt_q <= cnt_n;
    end
  end

  always_comb begin
    state_n = state;
    a_n     = a_q;
    q_n     = q_q;
    acc_n   = acc_q;
    cnt_n   = cnt_q;
    unique case (state)
      IDLE: begin
        if (in_valid) begin
          a_n     = {{2{a[WIDTH-1]}}, a};
          q_n     = {b, 1'b0};
          acc_n   = '0;
          cnt_n   = '0;
          state_n = RUN;
        end
      end
      RUN: begin
        acc_n = acc_q + ppx;
        q_n   = q_sh;
        cnt_n = cnt_q + 1'b1;
`ifdef BOOTH_EARLY_TERM_EN
        if (cnt_q == LAST || q_sh == '0 || q_sh == '1)
          state_n = DONE;
`else
        if (cnt_q == LAST)
          state_n = DONE;
`endif
      end
      DONE: begin
        if (out_ready)
          state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign product   = acc_q;

endmodule

// File: tb/tb_radix4_booth_seq_mult.sv
// Directed and random checks for radix4_booth_seq_mult at WIDTH=8.
// Latency expectations follow BOOTH_EARLY_TERM_EN when it is defined.
module tb_radix4_booth_seq_mult;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] product;
  logic        busy;

  int n_vec = 0;
  int n_err = 0;

  radix4_booth_seq_mult #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] p;
    int          lat_et;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_lat(input string name, input int lat, input int lat_et);
`ifdef BOOTH_EARLY_TERM_EN
    if (lat_et != 0) chk(name, lat, lat_et);
    else chk({name, "_range"}, (lat >= 1 && lat <= 4), 1);
`else
    chk(name, lat, 4);
`endif
  endtask

  task automatic run_op(input logic [7:0] ta, input logic [7:0] tb, input logic rdy,
                        output logic [15:0] p, output int lat);
    @(negedge clk);
    a = ta;
    b = tb;
    in_valid = 1'b1;
    out_ready = rdy;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    p = product;
  endtask

  vec_t vecs[14];
  logic [15:0] p;
  logic [15:0] ref_p;
  int lat;

  initial begin
    vecs[0]  = '{8'd7,    8'hFD, 16'hFFEB, 0};
    vecs[1]  = '{8'h80,   8'h80, 16'h4000, 0};
    vecs[2]  = '{8'h80,   8'h7F, 16'hC080, 0};
    vecs[3]  = '{8'h00,   8'h5A, 16'h0000, 0};
    vecs[4]  = '{8'd3,    8'd5,  16'h000F, 0};
    vecs[5]  = '{8'hFF,   8'hFF, 16'h0001, 0};
    vecs[6]  = '{8'h7F,   8'h7F, 16'h3F01, 0};
    vecs[7]  = '{8'h80,   8'h01, 16'hFF80, 1};
    vecs[8]  = '{8'h01,   8'h80, 16'hFF80, 0};
    vecs[9]  = '{8'd9,    8'h01, 16'h0009, 1};
    vecs[10] = '{8'd9,    8'hFF, 16'hFFF7, 1};
    vecs[11] = '{8'd9,    8'h40, 16'h0240, 4};
    vecs[12] = '{8'hF9,   8'hFD, 16'h0015, 0};
    vecs[13] = '{8'd100,  8'hCE, 16'hEC78, 0};

    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    a = '0;
    b = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_product", product, 0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 14; i++) begin
      run_op(vecs[i].a, vecs[i].b, 1'b1, p, lat);
      chk($sformatf("vec%0d_product", i), p, vecs[i].p);
      chk_lat($sformatf("vec%0d_latency", i), lat, vecs[i].lat_et);
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_pulse", i), out_valid, 0);
      chk($sformatf("vec%0d_idle", i), in_ready, 1);
    end

    // Backpressure: result held for 10 cycles
    run_op(8'd100, 8'hCE, 1'b0, p, lat);
    chk("bp_product", p, 16'hEC78);
    repeat (10) begin
      @(posedge clk);
      #1;
      chk("bp_valid_hold", out_valid, 1);
      chk("bp_product_hold", product, 16'hEC78);
      chk("bp_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_release_valid", out_valid, 0);
    chk("bp_release_ready", in_ready, 1);
    out_ready = 1'b0;

    // Reset during the second RUN cycle
    @(negedge clk);
    a = 8'h55;
    b = 8'h33;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("abort_in_ready", in_ready, 1);
    chk("abort_out_valid", out_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_product", product, 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("abort_no_stale", out_valid, 0);
    run_op(8'd3, 8'd5, 1'b1, p, lat);
    chk("after_abort_product", p, 16'h000F);
    chk_lat("after_abort_latency", lat, 0);
    @(posedge clk);
    #1;

    // Reset while waiting in DONE
    run_op(8'd7, 8'hFD, 1'b0, p, lat);
    chk("done_abort_pre", out_valid, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("done_abort_valid", out_valid, 0);
    chk("done_abort_product", product, 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("done_abort_no_stale", out_valid, 0);

    // Random operands with input gaps and output stalls
    for (int i = 0; i < 1000; i++) begin
      logic [7:0] ra, rb;
      ra = 8'($urandom);
      rb = 8'($urandom);
      ref_p = 16'($signed(ra) * $signed(rb));
      repeat ($urandom_range(0, 2)) @(negedge clk);
      run_op(ra, rb, 1'b0, p, lat);
      chk($sformatf("rand%0d_%0h_%0h", i, ra, rb), p, ref_p);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      if (out_valid) chk($sformatf("rand%0d_release", i), out_valid, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
